// File: rtl/psum_mem_pkg.sv
// psum_mem_pkg: op encodings and lane saturating add shared by the partial-sum memory
package psum_mem_pkg;
   localparam logic [1:0] OP_RD    = 2'b00;
   localparam logic [1:0] OP_WR    = 2'b01;
   localparam logic [1:0] OP_ACC   = 2'b10;
   localparam logic [1:0] OP_RDCLR = 2'b11;
   // Returns {saturated, clamped sum}; lanes arrive sign-extended to 32 bits, bw <= 31.
   function automatic logic [32:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int bw);
      logic signed [31:0] s, hi, lo;
      s  = a + b;
      hi = (32'sd1 <<< (bw - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      return (s > hi) ? {1'b1, hi} : (s < lo) ? {1'b1, lo} : {1'b0, s};
   endfunction
endpackage

// File: rtl/psum_mem_acc_lane.sv
// psum_lane_alu: per-lane saturating add, ReLU mask and saturation bit
module psum_lane_alu #(
   parameter int psum_bw = 16
) (
   input  logic [psum_bw-1:0] old_i,
   input  logic [psum_bw-1:0] data_i,
   input  logic               relu_i,
   output logic [psum_bw-1:0] sum_o,
   output logic [psum_bw-1:0] relu_o,
   output logic               sat_o
);
   import psum_mem_pkg::*;
   logic [32:0] res;
   logic        unused_hi;
   assign res       = sat_add(32'(signed'(old_i)), 32'(signed'(data_i)), psum_bw);
   assign sum_o     = res[psum_bw-1:0];
   assign sat_o     = res[32];
   assign unused_hi = ^res[31:psum_bw];
   assign relu_o    = (relu_i && old_i[psum_bw-1]) ? '0 : old_i;
endmodule

// File: rtl/psum_mem_acc.sv
// psum_mem_acc: two-stage partial-sum memory with read/write/accumulate/read-clear and write-back forwarding
module psum_mem_acc #(
   parameter int psum_bw    = 16,
   parameter int col        = 8,
   parameter int addr_width = 11
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [1:0]              req_op_i,
   input  logic [addr_width-1:0]   req_addr_i,
   input  logic [psum_bw*col-1:0]  req_data_i,
   input  logic                    req_relu_i,
   output logic                    rd_valid_o,
   input  logic                    rd_ready_i,
   output logic [psum_bw*col-1:0]  rd_data_o,
   output logic [col-1:0]          sat_flag_o
);
   import psum_mem_pkg::*;
   localparam int W = psum_bw * col;
   logic [W-1:0]            mem [2**addr_width];
   logic                    adv, wb_en, s2_rd;
   logic                    s1_v_q, s2_v_q, s1_relu_q, s2_relu_q, rd_valid_q;
   logic [1:0]              s1_op_q, s2_op_q;
   logic [addr_width-1:0]   s1_addr_q, s2_addr_q;
   logic [W-1:0]            s1_data_q, s2_data_q, s1_old_q, s2_old_q, rd_data_q;
   logic [W-1:0]            sum_d, relu_d, wb_d;
   logic [col-1:0]          sat_d, sat_q;
   assign adv         = !(rd_valid_q && !rd_ready_i);
   assign req_ready_o = adv;
   assign wb_en       = adv && s2_v_q && s2_op_q != OP_RD;
   assign s2_rd       = s2_v_q && (s2_op_q == OP_RD || s2_op_q == OP_RDCLR);
   assign wb_d        = s2_op_q == OP_WR ? s2_data_q : s2_op_q == OP_ACC ? sum_d : '0;
   assign rd_valid_o  = rd_valid_q;
   assign rd_data_o   = rd_data_q;
   assign sat_flag_o  = sat_q;
   for (genvar i = 0; i < col; i++) begin : g_lane
      psum_lane_alu #(.psum_bw(psum_bw)) u_lane (
         .old_i  (s2_old_q[i*psum_bw +: psum_bw]),
         .data_i (s2_data_q[i*psum_bw +: psum_bw]),
         .relu_i (s2_relu_q),
         .sum_o  (sum_d[i*psum_bw +: psum_bw]),
         .relu_o (relu_d[i*psum_bw +: psum_bw]),
         .sat_o  (sat_d[i])
      );
   end
   // Pipeline advance; both old-value captures take the retiring write-back when it targets the same entry
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s1_v_q     <= 1'b0;
         s1_op_q    <= '0;
         s1_addr_q  <= '0;
         s1_data_q  <= '0;
         s1_relu_q  <= 1'b0;
         s1_old_q   <= '0;
         s2_v_q     <= 1'b0;
         s2_op_q    <= '0;
         s2_addr_q  <= '0;
         s2_data_q  <= '0;
         s2_relu_q  <= 1'b0;
         s2_old_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         sat_q      <= '0;
      end else if (adv) begin
         s1_v_q     <= req_valid_i;
         s1_op_q    <= req_op_i;
         s1_addr_q  <= req_addr_i;
         s1_data_q  <= req_data_i;
         s1_relu_q  <= req_relu_i;
         s1_old_q   <= (wb_en && s2_addr_q == req_addr_i) ? wb_d : mem[req_addr_i];
         s2_v_q     <= s1_v_q;
         s2_op_q    <= s1_op_q;
         s2_addr_q  <= s1_addr_q;
         s2_data_q  <= s1_data_q;
         s2_relu_q  <= s1_relu_q;
         s2_old_q   <= (wb_en && s2_addr_q == s1_addr_q) ? wb_d : s1_old_q;
         rd_valid_q <= s2_rd;
         if (s2_rd) rd_data_q <= relu_d;
         if (s2_v_q && s2_op_q == OP_ACC) sat_q <= sat_q | sat_d;
      end
   end
   // Array write-back at the end of the S2 cycle; contents are intentionally not reset
   always_ff @(posedge clk_i) begin
      if (wb_en) mem[s2_addr_q] <= wb_d;
   end
endmodule

// File: tb/tb_psum_mem_acc.sv
// tb_psum_mem_acc: directed self-checking bench for psum_mem_acc
module tb_psum_mem_acc;
   logic         clk = 1'b0, rst = 1'b1;
   logic         req_valid = 1'b0, req_ready, req_relu = 1'b0;
   logic [1:0]   req_op = 2'b00;
   logic [10:0]  req_addr = '0;
   logic [127:0] req_data = '0, rd_data;
   logic         rd_valid, rd_ready = 1'b1;
   logic [7:0]   sat_flag;
   int           n_checks = 0, n_fail = 0;

   psum_mem_acc #(.psum_bw(16), .col(8), .addr_width(11)) dut (
      .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_addr_i(req_addr), .req_data_i(req_data), .req_relu_i(req_relu),
      .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .sat_flag_o(sat_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   function automatic logic [127:0] rep(input logic [15:0] v);
      return {8{v}};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [1:0] op, input logic [10:0] addr, input logic [127:0] data, input logic relu);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data; req_relu = relu;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic get_result(output logic [127:0] d, output int lat);
      lat = 0;
      while (!rd_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      d = rd_data;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(2);
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b exp 0", rd_valid); end
      n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h exp 0", rd_data); end
      n_checks++; if (sat_flag !== 8'h00) begin n_fail++; $display("FAIL reset_sat: got %h exp 00", sat_flag); end
      rst = 1'b0;
      idle(1);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
   endtask

   task automatic test_write_read;
      logic [127:0] d; int lat;
      send(2'b01, 11'd5, rep(16'h0001), 1'b0);
      send(2'b00, 11'd5, '0, 1'b0);
      get_result(d, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wr_rd_latency: got %0d exp 2", lat); end
      n_checks++; if (d !== rep(16'h0001)) begin n_fail++; $display("FAIL wr_rd_data: got %h exp %h", d, rep(16'h0001)); end
      idle(1);
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_drop: got %b exp 0", rd_valid); end
   endtask

   task automatic test_back_to_back;
      logic [127:0] d; int lat;
      send(2'b01, 11'd7, rep(16'd10), 1'b0);
      repeat (3) send(2'b10, 11'd7, rep(16'd3), 1'b0);
      send(2'b00, 11'd7, '0, 1'b0);
      get_result(d, lat);
      n_checks++; if (d !== rep(16'd19)) begin n_fail++; $display("FAIL b2b_acc: got %h exp %h", d, rep(16'd19)); end
      n_checks++; if (sat_flag !== 8'h00) begin n_fail++; $display("FAIL b2b_sat: got %h exp 00", sat_flag); end
      idle(1);
   endtask

   task automatic test_saturation;
      logic [127:0] v, a, e_raw, e_relu, d; int lat;
      v = '0; v[15:0] = 16'h7FF0; v[31:16] = 16'hFFFF; v[47:32] = 16'h8005;
      a = '0; a[15:0] = 16'h0100; a[47:32] = 16'hFFF0;
      e_raw = '0; e_raw[15:0] = 16'h7FFF; e_raw[31:16] = 16'hFFFF; e_raw[47:32] = 16'h8000;
      e_relu = '0; e_relu[15:0] = 16'h7FFF;
      send(2'b01, 11'd2, v, 1'b0);
      send(2'b10, 11'd2, a, 1'b0);
      send(2'b00, 11'd2, '0, 1'b0);
      send(2'b00, 11'd2, '0, 1'b1);
      get_result(d, lat);
      n_checks++; if (d !== e_raw) begin n_fail++; $display("FAIL sat_raw: got %h exp %h", d, e_raw); end
      idle(1);
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== e_relu) begin n_fail++; $display("FAIL sat_relu: got %b/%h exp 1/%h", rd_valid, rd_data, e_relu); end
      n_checks++; if (sat_flag !== 8'h05) begin n_fail++; $display("FAIL sat_flag: got %h exp 05", sat_flag); end
      idle(1);
   endtask

   task automatic test_read_clear;
      logic [127:0] d; int lat;
      send(2'b01, 11'd3, rep(16'd42), 1'b0);
      send(2'b11, 11'd3, '0, 1'b0);
      send(2'b00, 11'd3, '0, 1'b0);
      get_result(d, lat);
      n_checks++; if (d !== rep(16'd42) || lat !== 1) begin n_fail++; $display("FAIL rdclr_data: got %h lat %0d exp %h lat 1", d, lat, rep(16'd42)); end
      idle(1);
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== '0) begin n_fail++; $display("FAIL rdclr_after: got %b/%h exp 1/0", rd_valid, rd_data); end
      idle(1);
   endtask

   task automatic test_max_addr;
      logic [127:0] d; int lat;
      send(2'b01, 11'd2047, rep(16'h1234), 1'b0);
      send(2'b01, 11'd0, rep(16'h5555), 1'b0);
      send(2'b00, 11'd2047, '0, 1'b0);
      send(2'b00, 11'd0, '0, 1'b0);
      get_result(d, lat);
      n_checks++; if (d !== rep(16'h1234)) begin n_fail++; $display("FAIL max_addr: got %h exp %h", d, rep(16'h1234)); end
      idle(1);
      n_checks++; if (rd_data !== rep(16'h5555)) begin n_fail++; $display("FAIL addr0: got %h exp %h", rd_data, rep(16'h5555)); end
      idle(1);
   endtask

   task automatic test_stall;
      send(2'b01, 11'd20, rep(16'h000A), 1'b0);
      send(2'b01, 11'd21, rep(16'h000B), 1'b0);
      idle(2);
      rd_ready = 1'b0;
      send(2'b00, 11'd20, '0, 1'b0);
      send(2'b00, 11'd21, '0, 1'b0);
      idle(1);
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== rep(16'h000A)) begin n_fail++; $display("FAIL stall_first: got %b/%h exp 1/%h", rd_valid, rd_data, rep(16'h000A)); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b exp 0", req_ready); end
      idle(3);
      n_checks++; if (rd_data !== rep(16'h000A) || req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got %h/%b exp %h/0", rd_data, req_ready, rep(16'h000A)); end
      rd_ready = 1'b1;
      idle(1);
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== rep(16'h000B)) begin n_fail++; $display("FAIL stall_second: got %b/%h exp 1/%h", rd_valid, rd_data, rep(16'h000B)); end
      idle(1);
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b exp 0", rd_valid); end
   endtask

   task automatic test_reset_mid;
      logic [127:0] d; int lat;
      send(2'b01, 11'd9, rep(16'd100), 1'b0);
      idle(3);
      send(2'b00, 11'd9, '0, 1'b0);
      send(2'b10, 11'd9, rep(16'h7FFF), 1'b0);
      rst = 1'b1;
      idle(2);
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_valid: got %b exp 0", rd_valid); end
      n_checks++; if (sat_flag !== 8'h00) begin n_fail++; $display("FAIL rstmid_sat: got %h exp 00", sat_flag); end
      rst = 1'b0;
      idle(2);
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_result: got %b exp 0", rd_valid); end
      send(2'b00, 11'd9, '0, 1'b0);
      get_result(d, lat);
      n_checks++; if (d !== rep(16'd100)) begin n_fail++; $display("FAIL rstmid_addr9: got %h exp %h", d, rep(16'd100)); end
      idle(1);
   endtask

   initial begin
      #1;
      test_reset;
      test_write_read;
      test_back_to_back;
      test_saturation;
      test_read_clear;
      test_max_addr;
      test_stall;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/psum_mem_acc.md
# psum_mem_acc

Parametrised partial-sum memory that replaces the bare output SRAM after the corelet. Accepts read, write, accumulate (saturating read-modify-write) and read-and-clear requests over a valid/ready handshake, through a two-stage pipeline with write-back forwarding. Read results leave on a valid/ready port with optional per-read ReLU. Lets multi-pass tiles accumulate PSUMs in place, without a testbench round trip through the SFU.

## Interface
- `psum_bw`, 16: bits per lane, signed two's complement
- `col`, 8: lanes per entry
- `addr_width`, 11: address bits; depth = 2^addr_width entries
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_op`  in  2  00 read, 01 write, 10 accumulate, 11 read-and-clear
- `req_addr`  in  addr_width  entry address
- `req_data`  in  psum_bw*col  write/accumulate operand, lane k at [k*psum_bw +: psum_bw]
- `req_relu`  in  1  reads only: clamp negative lanes to 0 in returned data
- `rd_valid`  out  1  `rd_data` holds a read result
- `rd_ready`  in  1  consumer takes result when `rd_valid && rd_ready`
- `rd_data`  out  psum_bw*col  read result
- `sat_flag`  out  col  sticky per-lane saturation indicator

## Operation
- Stage S1: the accepted request is registered with its op, address, data and relu. The array is read at `req_addr` into S1.
- Stage S2: S1 advances into S2. S2 computes `old` and then performs the op:
  - `old` = the S1 array value, replaced by the forwarded write-back when an older write-type op to the same address retired in the cycle the S1 read happened.
  - write: entry ← data.
  - accumulate: entry ← per-lane saturating add `old + data`.
  - read: result ← `old`, ReLU-masked if relu.
  - read-and-clear: result ← `old`, ReLU-masked if relu; entry ← 0.
- Saturation:
  - Result above 2^(psum_bw-1)-1 is clamped to that value; result below -2^(psum_bw-1) is clamped to that value.
  - The lane's `sat_flag` bit sets on any clamp and stays set until reset.
- Write-type ops are write, accumulate and read-and-clear. S2 write-back occurs at the end of the S2 cycle.
- Read-type ops (read, read-and-clear) load `rd_data` and set `rd_valid` at the end of the S2 cycle.
- Stall: `adv = !(rd_valid && !rd_ready)` and `req_ready = adv`. When `adv` = 0, S1, S2 and the array hold, and no write-back occurs.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: `rd_valid` 0, `rd_data` 0, `sat_flag` 0, `req_ready` 1. S1 and S2 valid bits cleared.
- Reset asserted mid-operation drops in-flight ops. Their write-backs do not occur.
- Read latency: request accepted at edge t gives `rd_valid` = 1 after edge t+2.
- A write-type op accepted at edge t updates the array at edge t+2. A request accepted at edge t+1 to the same address observes the new value via forwarding.
- Back-to-back accumulates to one address at full rate accumulate correctly, with no lost update.
- `rd_valid` drops after a handshake edge unless a new read-type op retires on the same edge.
- Simultaneous `rd_ready` and a new read result retiring: the result is replaced, with no bubble.
- Address 2^addr_width-1 is a valid address; there is no wrap logic.

## Structure
- Shared package `psum_mem_pkg`: op encodings `OP_RD`, `OP_WR`, `OP_ACC`, `OP_RDCLR`, and the lane saturating-add function.
- Sub-module `psum_lane_alu`, one instance per lane, computes:
  - the saturating add,
  - the ReLU mask,
  - the saturation bit.

## Test plan
- Write 0x0001 to every lane of addr 5, then read addr 5 → `rd_data` all lanes 0x0001, `rd_valid` two cycles after acceptance.
- Three back-to-back accumulates of +3 to addr 7, which holds 10 → read returns 19 on all lanes, `sat_flag` = 0.
- Lane 0 holds 0x7FF0; accumulate +0x0100 → lane 0 reads 0x7FFF and `sat_flag[0]` = 1. Lane 1 of -1 with relu read → 0.
- Read-and-clear addr 3 holding 42 → returns 42; a following read of addr 3 returns 0.
- Hold `rd_ready` = 0 with two reads in flight → `req_ready` = 0, `rd_data` stable. Release → both results delivered in order, no loss.
- Assert `reset` between accepting an accumulate to addr 9 and its write-back → addr 9 unchanged; `rd_valid` and `sat_flag` = 0.
